// File: rtl/l0mdt_mtc_pkg.sv
// Shared constants for the MTC candidate path toward the SL link.
// No logic: widths and the candidate-word type only.
// Candidate valid flag is the MSB of the word.
package l0mdt_mtc_pkg;

   localparam int MTC2SL_LEN         = 32;
   localparam int MTC_ARB_DROP_CNT_W = 16;

   typedef logic [MTC2SL_LEN-1:0] mtc2sl_t;

endpackage

// File: rtl/mtc_cand_fifo.sv
// Small candidate FIFO with combinational head (dout = oldest entry).
// Latency: a push is visible on dout/empty one edge later.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
module mtc_cand_fifo
   import l0mdt_mtc_pkg::*;
#(
   parameter int W          = MTC2SL_LEN,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic                          push,
   input  logic [W-1:0]                  din,
   input  logic                          pop,
   output logic [W-1:0]                  dout,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int            AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

   logic [W-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // When full, the write lands in the slot being read out on this same edge.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/mtc_sl_link_arbiter.sv
// Round-robin merge of per-slot MTC candidates onto one registered stream.
// Latency: 2 edges from input to out_valid when idle; 1 word/cycle sustained.
// Backpressure: out_ready low holds the output; full inputs drop and count.
module mtc_sl_link_arbiter
   import l0mdt_mtc_pkg::*;
#(
   parameter  int N_IN       = 3,
   parameter  int W          = MTC2SL_LEN,
   parameter  int FIFO_DEPTH = 4,
   parameter  int DROP_CNT_W = MTC_ARB_DROP_CNT_W,
   localparam int SRC_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [W-1:0]          mtc_in [N_IN],
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [W-1:0]          out_data,
   output logic [SRC_W-1:0]      out_src,
   output logic [N_IN-1:0]       fifo_full,
   output logic [DROP_CNT_W-1:0] drop_cnt [N_IN],
   input  logic                  clear_cnt
);

   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [W-1:0]     fifo_dout [N_IN];
   logic [CW-1:0]    fifo_cnt  [N_IN];
   logic [N_IN-1:0]  fifo_empty;
   logic [N_IN-1:0]  push_req;
   logic [N_IN-1:0]  push_ok;
   logic [N_IN-1:0]  pop;
   logic [N_IN-1:0]  drop;

   logic [SRC_W-1:0] last_grant;
   logic             load;
   logic             gnt_vld;
   logic [SRC_W-1:0] gnt_idx;
   logic [W-1:0]     gnt_dat;
   logic             hi_vld;
   logic [SRC_W-1:0] hi_idx;
   logic             lo_vld;
   logic [SRC_W-1:0] lo_idx;

   assign load = !out_valid || out_ready;

   // Lowest non-empty index above last_grant wins; otherwise wrap to the lowest overall.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (!fifo_empty[i] && (i > int'(last_grant))) begin
            hi_vld = 1'b1;
            hi_idx = SRC_W'(i);
         end
         if (!fifo_empty[i]) begin
            lo_vld = 1'b1;
            lo_idx = SRC_W'(i);
         end
      end
      gnt_vld = hi_vld || lo_vld;
      gnt_idx = hi_vld ? hi_idx : lo_idx;
   end

   always_comb begin
      gnt_dat = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (gnt_vld && (gnt_idx == SRC_W'(i))) begin
            gnt_dat = fifo_dout[i];
         end
      end
   end

   for (genvar g = 0; g < N_IN; g++) begin : g_in
      assign push_req[g] = mtc_in[g][W-1];
      assign pop[g]      = load && gnt_vld && (gnt_idx == SRC_W'(g));
      assign push_ok[g]  = push_req[g] && ((fifo_cnt[g] < DEPTH_C) || pop[g]);
      assign drop[g]     = push_req[g] && !push_ok[g];

      mtc_cand_fifo #(
         .W          (W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clock (clock),
         .rst   (rst),
         .push  (push_ok[g]),
         .din   (mtc_in[g]),
         .pop   (pop[g]),
         .dout  (fifo_dout[g]),
         .count (fifo_cnt[g]),
         .full  (fifo_full[g]),
         .empty (fifo_empty[g])
      );

      always_ff @(posedge clock) begin
         if (!rst || clear_cnt) begin
            drop_cnt[g] <= '0;
         end else if (drop[g] && (drop_cnt[g] != '1)) begin
            drop_cnt[g] <= drop_cnt[g] + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= '0;
         last_grant <= SRC_W'(N_IN - 1);
      end else if (load) begin
         out_valid <= gnt_vld;
         out_data  <= gnt_dat;
         if (gnt_vld) begin
            out_src    <= gnt_idx;
            last_grant <= gnt_idx;
         end
      end
   end

endmodule
